// File: rtl/toggle_pkg.sv
// Shared types and defaults for the toggle-signalling receiver.
package toggle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_STALLED = 2'd2
    } state_t;

    localparam int DEFAULT_TIMEOUT = 1000;

endpackage

// File: rtl/toggle_edge_det.sv
// Turns level changes on the toggle line into single-cycle events.
// Optional TOGGLE_RX_SYNC_EN adds a two-flop synchronizer ahead of the sampler.
module toggle_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic t_in,
    output logic evt
);
    logic t_s;
    logic t_d;
    logic t_prev;

`ifdef TOGGLE_RX_SYNC_EN
    localparam int ARM_DLY = 4;
    logic [1:0] sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], t_in};
        end
    end

    assign t_s = sync[1];
`else
    localparam int ARM_DLY = 2;

    assign t_s = t_in;
`endif

    // Arming waits until t_prev holds a real sample, so the first level seen is reference only.
    logic [ARM_DLY-1:0] arm_sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            t_d    <= 1'b0;
            t_prev <= 1'b0;
            arm_sr <= '0;
        end else begin
            t_d    <= t_s;
            t_prev <= t_d;
            arm_sr <= {arm_sr[ARM_DLY-2:0], 1'b1};
        end
    end

    assign evt = arm_sr[ARM_DLY-1] & (t_d ^ t_prev);

endmodule

// File: rtl/toggle_rx.sv
// Toggle-link receiver: event strobe, saturating count, period measurement and link status.
// Define TOGGLE_RX_SYNC_EN to synchronize an asynchronous t_in (adds two cycles of latency).
module toggle_rx
    import toggle_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int PER_W   = 16,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             t_in,
    input  logic             clr,
    output logic             pulse,
    output logic [CNT_W-1:0] count,
    output logic [PER_W-1:0] period,
    output logic             period_valid,
    output logic [1:0]       state,
    output logic             stall_pulse
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [PER_W-1:0] PER_MAX = '1;
    localparam logic [PER_W-1:0] TO_VAL  = PER_W'(TIMEOUT);

    logic             evt;
    logic             stall_now;
    logic [PER_W-1:0] timer;
    state_t           state_r;

    toggle_edge_det u_edge (
        .clk   (clk),
        .reset (reset),
        .t_in  (t_in),
        .evt   (evt)
    );

    // An event in the timeout cycle keeps the link active.
    assign stall_now = (state_r == ST_ACTIVE) && !evt && (timer == TO_VAL);

    always_ff @(posedge clk) begin
        if (reset) begin
            pulse        <= 1'b0;
            count        <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            stall_pulse  <= 1'b0;
            timer        <= '0;
            state_r      <= ST_IDLE;
        end else begin
            pulse        <= evt;
            period_valid <= evt && (state_r != ST_IDLE);
            stall_pulse  <= stall_now;

            if (evt) begin
                timer  <= PER_W'(1);
                period <= timer;
            end else if (timer != PER_MAX) begin
                timer <= timer + PER_W'(1);
            end

            if (clr) begin
                count <= evt ? CNT_W'(1) : '0;
            end else if (evt && (count != CNT_MAX)) begin
                count <= count + CNT_W'(1);
            end

            case (state_r)
                ST_IDLE:    if (evt) state_r <= ST_ACTIVE;
                ST_ACTIVE:  if (stall_now) state_r <= ST_STALLED;
                ST_STALLED: if (evt) state_r <= ST_ACTIVE;
                default:    state_r <= ST_IDLE;
            endcase
        end
    end

    assign state = state_r;

endmodule

// File: tb/tb_toggle_rx.sv
// Directed bench for toggle_rx with a pulse/stall scoreboard keyed on expected cycle numbers.
module tb_toggle_rx;

`ifdef TOGGLE_RX_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif
    localparam int TO      = 50;
    localparam int CNT_MAX = 15;

    typedef struct {
        int         cyc;
        logic [3:0] cnt;
        logic       pv;
        logic [15:0] per;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        t_in;
    logic        clr;
    logic        pulse;
    logic [3:0]  count;
    logic [15:0] period;
    logic        period_valid;
    logic [1:0]  state;
    logic        stall_pulse;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   last_p = -1;
    logic [3:0] m_cnt = '0;
    exp_t exp_q[$];
    int   stall_q[$];

    toggle_rx #(.CNT_W(4), .PER_W(16), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .t_in         (t_in),
        .clr          (clr),
        .pulse        (pulse),
        .count        (count),
        .period       (period),
        .period_valid (period_valid),
        .state        (state),
        .stall_pulse  (stall_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Flip the line and queue the pulse it must produce LAT cycles later.
    task automatic toggle_ev(input bit with_clr);
        exp_t e;
        int   p;
        t_in = ~t_in;
        p = cyc + LAT;
        if (with_clr) m_cnt = 4'd1;
        else if (m_cnt != CNT_MAX) m_cnt = m_cnt + 4'd1;
        e.cyc = p;
        e.cnt = m_cnt;
        e.pv  = (last_p >= 0);
        e.per = (p - last_p > 65535) ? 16'hFFFF : 16'(p - last_p);
        last_p = p;
        exp_q.push_back(e);
        if (with_clr) begin
            repeat (LAT - 1) step();
            clr = 1'b1;
            step();
            clr = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            chk("pulse", {31'd0, pulse}, 32'd1);
            chk("count_at_pulse", {28'd0, count}, {28'd0, exp_q[0].cnt});
            chk("period_valid", {31'd0, period_valid}, {31'd0, exp_q[0].pv});
            if (exp_q[0].pv) chk("period", {16'd0, period}, {16'd0, exp_q[0].per});
            void'(exp_q.pop_front());
        end else if (pulse || period_valid) begin
            chk("pulse_unexpected", {30'd0, period_valid, pulse}, 32'd0);
        end
        if (stall_q.size() != 0 && stall_q[0] == cyc) begin
            chk("stall_pulse", {31'd0, stall_pulse}, 32'd1);
            void'(stall_q.pop_front());
        end else if (stall_pulse) begin
            chk("stall_unexpected", {31'd0, stall_pulse}, 32'd0);
        end
    end

    initial begin
        reset = 1'b1;
        t_in  = 1'b1;
        clr   = 1'b0;
        repeat (3) step();
        chk("rst_pulse", {31'd0, pulse}, 32'd0);
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_period", {16'd0, period}, 32'd0);
        chk("rst_stall", {31'd0, stall_pulse}, 32'd0);

        // Static high line out of reset must not create an event.
        reset = 1'b0;
        repeat (20) step();
        chk("static_count", {28'd0, count}, 32'd0);
        chk("static_state", {30'd0, state}, 32'd0);

        // Five events ten cycles apart.
        for (int i = 0; i < 5; i++) begin
            toggle_ev(1'b0);
            repeat (10) step();
        end
        chk("five_count", {28'd0, count}, 32'd5);
        chk("five_state", {30'd0, state}, 32'd1);

        // Silence until the link stalls.
        stall_q.push_back(last_p + TO);
        while (cyc < last_p + TO + 3) step();
        chk("stalled_state", {30'd0, state}, 32'd2);

        // Recovery event from STALLED.
        toggle_ev(1'b0);
        repeat (LAT + 1) step();
        chk("recover_state", {30'd0, state}, 32'd1);
        chk("recover_count", {28'd0, count}, 32'd6);

        // Event landing exactly on the timeout cycle wins.
        while (cyc < last_p + TO - LAT) step();
        toggle_ev(1'b0);
        repeat (LAT + 3) step();
        chk("race_state", {30'd0, state}, 32'd1);

        // Toggle every cycle for eight cycles; count saturates at 15.
        for (int i = 0; i < 8; i++) begin
            toggle_ev(1'b0);
            step();
        end
        repeat (LAT + 1) step();
        chk("burst_count", {28'd0, count}, 32'd15);

        // Clear with no event.
        clr = 1'b1;
        step();
        clr = 1'b0;
        m_cnt = '0;
        step();
        chk("clr_alone", {28'd0, count}, 32'd0);

        // Twenty events, clear coinciding with the third.
        for (int i = 1; i <= 20; i++) begin
            toggle_ev(i == 3);
            repeat (4) step();
        end
        repeat (LAT + 1) step();
        chk("sat_count", {28'd0, count}, 32'd15);
        chk("sat_state", {30'd0, state}, 32'd1);

        // Reset one cycle after a change discards the change.
        t_in = ~t_in;
        step();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        last_p = -1;
        m_cnt = '0;
        repeat (10) step();
        chk("midrst_count", {28'd0, count}, 32'd0);
        chk("midrst_state", {30'd0, state}, 32'd0);

        // First event after reset: pulse without period_valid.
        toggle_ev(1'b0);
        repeat (LAT + 3) step();
        chk("post_rst_count", {28'd0, count}, 32'd1);
        chk("post_rst_state", {30'd0, state}, 32'd1);

        chk("pulse_q_empty", exp_q.size(), 32'd0);
        chk("stall_q_empty", stall_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
